// File: rtl/axi_page_remap.sv
// AXI address-translation stage: 4 KiB page remap through a small programmable table,
// one-deep AW/AR register stages, W/B/R pass-through. Optional miss counters: AXI_PAGE_REMAP_MISS_CNT_EN.

package axi_page_remap_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } slv_ax_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } mst_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        slv_ax_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        slv_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        mst_ax_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        mst_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

    typedef axi_resp_t slv_resp_t;
    typedef axi_resp_t mst_resp_t;

endpackage

module axi_page_remap #(
    parameter int  SlvAddrWidth = 32,
    parameter int  MstAddrWidth = 48,
    parameter int  NumEntries   = 8,
    parameter type slv_req_t    = axi_page_remap_pkg::slv_req_t,
    parameter type slv_resp_t   = axi_page_remap_pkg::slv_resp_t,
    parameter type mst_req_t    = axi_page_remap_pkg::mst_req_t,
    parameter type mst_resp_t   = axi_page_remap_pkg::mst_resp_t,
    localparam int IdxWidth     = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  slv_req_t                  slv_req_i,
    output slv_resp_t                 slv_resp_o,
    output mst_req_t                  mst_req_o,
    input  mst_resp_t                 mst_resp_i,
    input  logic                      cfg_we_i,
    input  logic [IdxWidth-1:0]       cfg_idx_i,
    input  logic                      cfg_valid_i,
    input  logic [SlvAddrWidth-13:0]  cfg_vpage_i,
    input  logic [MstAddrWidth-13:0]  cfg_ppage_i,
    input  logic [MstAddrWidth-13:0]  default_ppage_i,
    output logic                      miss_o
`ifdef AXI_PAGE_REMAP_MISS_CNT_EN
    ,
    input  logic                      miss_cnt_clr_i,
    output logic [15:0]               aw_miss_cnt_o,
    output logic [15:0]               ar_miss_cnt_o
`endif
);

    localparam int VpWidth = SlvAddrWidth - 12;
    localparam int PpWidth = MstAddrWidth - 12;

    logic [NumEntries-1:0] tbl_valid_q;
    logic [VpWidth-1:0]    tbl_vpage_q [NumEntries];
    logic [PpWidth-1:0]    tbl_ppage_q [NumEntries];

    // Holds both captured AX beats; aw_valid/ar_valid double as the stage-full flags.
    mst_req_t ax_q, ax_d;

    logic               aw_hit, ar_hit;
    logic [PpWidth-1:0] aw_ppage, ar_ppage;
    logic               aw_rdy, ar_rdy;
    logic               aw_acc, ar_acc;
    logic               aw_out, ar_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_valid_q <= '0;
            for (int i = 0; i < NumEntries; i++) begin
                tbl_vpage_q[i] <= '0;
                tbl_ppage_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            // Indices beyond the table match no entry and are dropped.
            for (int i = 0; i < NumEntries; i++) begin
                if (cfg_idx_i == IdxWidth'(i)) begin
                    tbl_valid_q[i] <= cfg_valid_i;
                    tbl_vpage_q[i] <= cfg_vpage_i;
                    tbl_ppage_q[i] <= cfg_ppage_i;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        aw_hit   = 1'b0;
        aw_ppage = default_ppage_i;
        ar_hit   = 1'b0;
        ar_ppage = default_ppage_i;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (tbl_valid_q[i] && tbl_vpage_q[i] == slv_req_i.aw.addr[SlvAddrWidth-1:12]) begin
                aw_hit   = 1'b1;
                aw_ppage = tbl_ppage_q[i];
            end
            if (tbl_valid_q[i] && tbl_vpage_q[i] == slv_req_i.ar.addr[SlvAddrWidth-1:12]) begin
                ar_hit   = 1'b1;
                ar_ppage = tbl_ppage_q[i];
            end
        end
    end

    always_comb begin
        aw_rdy = !ax_q.aw_valid || mst_resp_i.aw_ready;
        ar_rdy = !ax_q.ar_valid || mst_resp_i.ar_ready;
        aw_acc = slv_req_i.aw_valid && aw_rdy;
        ar_acc = slv_req_i.ar_valid && ar_rdy;
        aw_out = ax_q.aw_valid && mst_resp_i.aw_ready;
        ar_out = ax_q.ar_valid && mst_resp_i.ar_ready;
    end

    always_comb begin
        ax_d = ax_q;
        if (aw_acc) begin
            ax_d.aw_valid = 1'b1;
            ax_d.aw.id    = slv_req_i.aw.id;
            ax_d.aw.addr  = {aw_ppage, slv_req_i.aw.addr[11:0]};
            ax_d.aw.len   = slv_req_i.aw.len;
            ax_d.aw.size  = slv_req_i.aw.size;
            ax_d.aw.burst = slv_req_i.aw.burst;
            ax_d.aw.lock  = slv_req_i.aw.lock;
            ax_d.aw.cache = slv_req_i.aw.cache;
            ax_d.aw.prot  = slv_req_i.aw.prot;
            ax_d.aw.qos   = slv_req_i.aw.qos;
        end else if (aw_out) begin
            ax_d.aw_valid = 1'b0;
        end
        if (ar_acc) begin
            ax_d.ar_valid = 1'b1;
            ax_d.ar.id    = slv_req_i.ar.id;
            ax_d.ar.addr  = {ar_ppage, slv_req_i.ar.addr[11:0]};
            ax_d.ar.len   = slv_req_i.ar.len;
            ax_d.ar.size  = slv_req_i.ar.size;
            ax_d.ar.burst = slv_req_i.ar.burst;
            ax_d.ar.lock  = slv_req_i.ar.lock;
            ax_d.ar.cache = slv_req_i.ar.cache;
            ax_d.ar.prot  = slv_req_i.ar.prot;
            ax_d.ar.qos   = slv_req_i.ar.qos;
        end else if (ar_out) begin
            ax_d.ar_valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ax_q <= '0;
        end else begin
            ax_q <= ax_d;
        end
    end

    always_comb begin
        mst_req_o         = ax_q;
        mst_req_o.w       = slv_req_i.w;
        mst_req_o.w_valid = slv_req_i.w_valid;
        mst_req_o.b_ready = slv_req_i.b_ready;
        mst_req_o.r_ready = slv_req_i.r_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_rdy;
        slv_resp_o.ar_ready = ar_rdy;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b        = mst_resp_i.b;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.r        = mst_resp_i.r;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
    end

    assign miss_o = (aw_acc && !aw_hit) || (ar_acc && !ar_hit);

`ifdef AXI_PAGE_REMAP_MISS_CNT_EN
    logic [15:0] aw_miss_cnt_q, ar_miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_miss_cnt_q <= '0;
            ar_miss_cnt_q <= '0;
        end else if (miss_cnt_clr_i) begin
            aw_miss_cnt_q <= '0;
            ar_miss_cnt_q <= '0;
        end else begin
            if (aw_acc && !aw_hit && aw_miss_cnt_q != 16'hFFFF) begin
                aw_miss_cnt_q <= aw_miss_cnt_q + 16'd1;
            end
            if (ar_acc && !ar_hit && ar_miss_cnt_q != 16'hFFFF) begin
                ar_miss_cnt_q <= ar_miss_cnt_q + 16'd1;
            end
        end
    end

    assign aw_miss_cnt_o = aw_miss_cnt_q;
    assign ar_miss_cnt_o = ar_miss_cnt_q;
`endif

endmodule
